// File: rtl/tb_pkg.sv
// Shared opcode encoding and default width for the multicycle ALU and its lab bench.
// Encodings 5..7 are deliberately left undefined and complete as a zero result.
package tb_pkg;

  localparam int ALU_WIDTH_DEFAULT = 8;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_MUL = 3'd2,
    OP_DIV = 3'd3,
    OP_MOD = 3'd4
  } opcode_t;

  function automatic logic is_divmod(input opcode_t op);
    return (op == OP_DIV) || (op == OP_MOD);
  endfunction

endpackage

// File: rtl/multicycle_alu_divmod.sv
// Iterative restoring divider: one quotient bit per step, WIDTH steps after a load.
// quotient/remainder present the value after the step in progress so the parent can register it on the final edge.
module seq_divmod
  import tb_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH_DEFAULT
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             last
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dsr_q, dsr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;

  always_comb begin
    quo_d   = quo_q;
    rem_d   = rem_q;
    dsr_d   = dsr_q;
    cnt_d   = cnt_q;
    shifted = {rem_q, quo_q[WIDTH-1]};
    trial   = shifted - {1'b0, dsr_q};
    if (load) begin
      quo_d = dividend;
      rem_d = '0;
      dsr_d = divisor;
      cnt_d = CNT_W'(WIDTH - 1);
    end else if (step) begin
      // A clear top bit of the trial difference means the divisor fits.
      if (!trial[WIDTH]) begin
        rem_d = trial[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], 1'b1};
      end else begin
        rem_d = shifted[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], 1'b0};
      end
      if (cnt_q != '0) begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      quo_q <= '0;
      rem_q <= '0;
      dsr_q <= '0;
      cnt_q <= '0;
    end else begin
      quo_q <= quo_d;
      rem_q <= rem_d;
      dsr_q <= dsr_d;
      cnt_q <= cnt_d;
    end
  end

  assign quotient  = quo_d;
  assign remainder = rem_d;
  assign last      = (cnt_q == '0);

endmodule

// File: rtl/multicycle_alu.sv
// Multicycle unsigned ALU with start/busy/done handshake: ADD/SUB in one cycle,
// shift-add MUL and restoring DIV/MOD over WIDTH cycles.
module multicycle_alu
  import tb_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH_DEFAULT
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  opcode_t          mode_select,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] c_hi,
  output logic             carry,
  output logic             div_zero
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } alu_state_t;

  alu_state_t         state_q, state_d;
  opcode_t            op_q, op_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   c_q, c_d;
  logic [WIDTH-1:0]   c_hi_q, c_hi_d;
  logic               carry_q, carry_d;
  logic               div_zero_q, div_zero_d;

  logic [WIDTH:0]     sum_add;
  logic [WIDTH:0]     diff_sub;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;

  logic               div_load;
  logic               div_step;
  logic [WIDTH-1:0]   div_quo;
  logic [WIDTH-1:0]   div_rem;
  logic               div_last;

  assign div_load = (state_q == IDLE) && start && is_divmod(mode_select) && (b != '0);
  assign div_step = (state_q == CALC) && is_divmod(op_q);

  seq_divmod #(
    .WIDTH(WIDTH)
  ) u_divmod (
    .clock    (clock),
    .reset_n  (reset_n),
    .load     (div_load),
    .step     (div_step),
    .dividend (a),
    .divisor  (b),
    .quotient (div_quo),
    .remainder(div_rem),
    .last     (div_last)
  );

  // The product register holds {partial sum, remaining multiplier bits}; each step
  // adds the multiplicand into the upper half and shifts the whole thing right.
  always_comb begin
    sum_add  = {1'b0, a} + {1'b0, b};
    diff_sub = {1'b0, a} - {1'b0, b};
    mul_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
    mul_next = {mul_sum, prod_q[WIDTH-1:1]};
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    mcand_d    = mcand_q;
    prod_d     = prod_q;
    cnt_d      = cnt_q;
    c_d        = c_q;
    c_hi_d     = c_hi_q;
    carry_d    = carry_q;
    div_zero_d = div_zero_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          op_d    = mode_select;
          mcand_d = a;
          case (mode_select)
            OP_ADD: begin
              c_d        = sum_add[WIDTH-1:0];
              c_hi_d     = '0;
              carry_d    = sum_add[WIDTH];
              div_zero_d = 1'b0;
              state_d    = DONE;
            end
            OP_SUB: begin
              c_d        = diff_sub[WIDTH-1:0];
              c_hi_d     = '0;
              carry_d    = diff_sub[WIDTH];
              div_zero_d = 1'b0;
              state_d    = DONE;
            end
            OP_MUL: begin
              prod_d  = {{WIDTH{1'b0}}, b};
              cnt_d   = CNT_W'(WIDTH - 1);
              state_d = CALC;
            end
            OP_DIV, OP_MOD: begin
              if (b == '0) begin
                c_d        = (mode_select == OP_DIV) ? '1 : a;
                c_hi_d     = (mode_select == OP_DIV) ? a : '1;
                carry_d    = 1'b0;
                div_zero_d = 1'b1;
                state_d    = DONE;
              end else begin
                cnt_d   = CNT_W'(WIDTH - 1);
                state_d = CALC;
              end
            end
            default: begin
              c_d        = '0;
              c_hi_d     = '0;
              carry_d    = 1'b0;
              div_zero_d = 1'b0;
              state_d    = DONE;
            end
          endcase
        end
      end
      CALC: begin
        if (op_q == OP_MUL) begin
          prod_d = mul_next;
          if (cnt_q == '0) begin
            c_d        = mul_next[WIDTH-1:0];
            c_hi_d     = mul_next[2*WIDTH-1:WIDTH];
            carry_d    = |mul_next[2*WIDTH-1:WIDTH];
            div_zero_d = 1'b0;
            state_d    = DONE;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end else if (div_last) begin
          c_d        = (op_q == OP_DIV) ? div_quo : div_rem;
          c_hi_d     = (op_q == OP_DIV) ? div_rem : div_quo;
          carry_d    = 1'b0;
          div_zero_d = 1'b0;
          cnt_d      = '0;
          state_d    = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      op_q       <= OP_ADD;
      mcand_q    <= '0;
      prod_q     <= '0;
      cnt_q      <= '0;
      c_q        <= '0;
      c_hi_q     <= '0;
      carry_q    <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      mcand_q    <= mcand_d;
      prod_q     <= prod_d;
      cnt_q      <= cnt_d;
      c_q        <= c_d;
      c_hi_q     <= c_hi_d;
      carry_q    <= carry_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign c        = c_q;
  assign c_hi     = c_hi_q;
  assign carry    = carry_q;
  assign div_zero = div_zero_q;

endmodule

// File: tb/tb_multicycle_alu.sv
// Bench for multicycle_alu at WIDTH=8 and WIDTH=16: a timeline model predicts every
// output each cycle, directed lab cases pin literal results, then random traffic follows.
module tb_multicycle_alu;
  import tb_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start8, start16;
  logic [7:0]  a8, b8;
  logic [15:0] a16, b16;
  opcode_t     mode8, mode16;
  logic        busy8, done8, carry8, dz8;
  logic [7:0]  c8, chi8;
  logic        busy16, done16, carry16, dz16;
  logic [15:0] c16, chi16;

  int checks = 0;
  int passes = 0;
  int cyc = 0;

  // Model: per instance, when the accepted op completes and what it must produce.
  logic        in_flight [2] = '{1'b0, 1'b0};
  int          done_edge [2] = '{0, 0};
  logic [31:0] p_c [2], p_chi [2];
  logic        p_carry [2], p_dz [2];
  logic [31:0] e_c [2] = '{0, 0};
  logic [31:0] e_chi [2] = '{0, 0};
  logic        e_carry [2] = '{1'b0, 1'b0};
  logic        e_dz [2] = '{1'b0, 1'b0};
  logic        e_busy [2] = '{1'b0, 1'b0};
  logic        e_done [2] = '{1'b0, 1'b0};

  always #5 clock = ~clock;

  multicycle_alu #(.WIDTH(8)) dut8 (
    .clock(clock), .reset_n(reset_n), .start(start8), .a(a8), .b(b8),
    .mode_select(mode8), .busy(busy8), .done(done8), .c(c8), .c_hi(chi8),
    .carry(carry8), .div_zero(dz8)
  );

  multicycle_alu #(.WIDTH(16)) dut16 (
    .clock(clock), .reset_n(reset_n), .start(start16), .a(a16), .b(b16),
    .mode_select(mode16), .busy(busy16), .done(done16), .c(c16), .c_hi(chi16),
    .carry(carry16), .div_zero(dz16)
  );

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
  endtask

  task automatic compute(input opcode_t op, input logic [31:0] a, input logic [31:0] b, input int w,
                         output logic [31:0] c, output logic [31:0] chi,
                         output logic cy, output logic dz, output int lat);
    logic [63:0] mask, p, aa, bb;
    mask = (64'd1 << w) - 64'd1;
    aa = {32'd0, a};
    bb = {32'd0, b};
    c = 0; chi = 0; cy = 1'b0; dz = 1'b0; lat = 0;
    case (op)
      OP_ADD: begin p = aa + bb; c = 32'(p & mask); cy = p[w]; end
      OP_SUB: begin c = 32'((aa - bb) & mask); cy = (aa < bb); end
      OP_MUL: begin
        p = aa * bb; c = 32'(p & mask); chi = 32'(p >> w); cy = (chi != 0); lat = w;
      end
      OP_DIV: begin
        if (b == 0) begin c = 32'(mask); chi = a; dz = 1'b1; end
        else begin c = a / b; chi = a % b; lat = w; end
      end
      OP_MOD: begin
        if (b == 0) begin c = a; chi = 32'(mask); dz = 1'b1; end
        else begin c = a % b; chi = a / b; lat = w; end
      end
      default: ;
    endcase
  endtask

  task automatic model_edge(input int i, input int w, input logic st, input logic [31:0] a,
                            input logic [31:0] b, input opcode_t op);
    int lat;
    if (!reset_n) begin
      in_flight[i] = 1'b0;
      e_c[i] = 0; e_chi[i] = 0; e_carry[i] = 1'b0; e_dz[i] = 1'b0;
      e_busy[i] = 1'b0; e_done[i] = 1'b0;
      return;
    end
    // A new request is only seen once the previous done cycle has passed.
    if (!in_flight[i] || cyc >= done_edge[i] + 2) begin
      in_flight[i] = 1'b0;
      if (st) begin
        compute(op, a, b, w, p_c[i], p_chi[i], p_carry[i], p_dz[i], lat);
        in_flight[i] = 1'b1;
        done_edge[i] = cyc + lat;
      end
    end
    if (in_flight[i] && cyc == done_edge[i]) begin
      e_c[i] = p_c[i]; e_chi[i] = p_chi[i]; e_carry[i] = p_carry[i]; e_dz[i] = p_dz[i];
    end
    e_busy[i] = in_flight[i] && (cyc <= done_edge[i]);
    e_done[i] = in_flight[i] && (cyc == done_edge[i]);
  endtask

  always @(posedge clock) begin
    cyc = cyc + 1;
    model_edge(0, 8, start8, 32'(a8), 32'(b8), mode8);
    model_edge(1, 16, start16, 32'(a16), 32'(b16), mode16);
    #1;
    check_output("busy8", 32'(busy8), 32'(e_busy[0]));
    check_output("done8", 32'(done8), 32'(e_done[0]));
    check_output("c8", 32'(c8), e_c[0]);
    check_output("c_hi8", 32'(chi8), e_chi[0]);
    check_output("carry8", 32'(carry8), 32'(e_carry[0]));
    check_output("div_zero8", 32'(dz8), 32'(e_dz[0]));
    check_output("busy16", 32'(busy16), 32'(e_busy[1]));
    check_output("done16", 32'(done16), 32'(e_done[1]));
    check_output("c16", 32'(c16), e_c[1]);
    check_output("c_hi16", 32'(chi16), e_chi[1]);
    check_output("carry16", 32'(carry16), 32'(e_carry[1]));
    check_output("div_zero16", 32'(dz16), 32'(e_dz[1]));
  end

  // Called just after a negedge; leaves the start pulse one cycle wide.
  task automatic apply_stimulus(input int i, input opcode_t op, input logic [31:0] a, input logic [31:0] b);
    if (i == 0) begin a8 = a[7:0]; b8 = b[7:0]; mode8 = op; start8 = 1'b1; end
    else begin a16 = a[15:0]; b16 = b[15:0]; mode16 = op; start16 = 1'b1; end
    @(negedge clock);
    start8 = 1'b0;
    start16 = 1'b0;
  endtask

  task automatic wait_idle(input int i);
    int n = 0;
    while (((i == 0) ? busy8 : busy16) && n < 40) begin
      @(negedge clock);
      n++;
    end
    check_output("idle_timeout", 32'(n >= 40), 32'd0);
  endtask

  task automatic expect_result(input int i, input logic [31:0] c, input logic [31:0] chi,
                               input logic cy, input logic dz);
    check_output("lit_c", (i == 0) ? 32'(c8) : 32'(c16), c);
    check_output("lit_c_hi", (i == 0) ? 32'(chi8) : 32'(chi16), chi);
    check_output("lit_carry", (i == 0) ? 32'(carry8) : 32'(carry16), 32'(cy));
    check_output("lit_div_zero", (i == 0) ? 32'(dz8) : 32'(dz16), 32'(dz));
  endtask

  initial begin
    start8 = 1'b0; start16 = 1'b0;
    a8 = '0; b8 = '0; a16 = '0; b16 = '0;
    mode8 = OP_ADD; mode16 = OP_ADD;
    repeat (3) @(negedge clock);
    expect_result(0, 0, 0, 1'b0, 1'b0);
    reset_n = 1'b1;
    @(negedge clock);

    apply_stimulus(0, OP_ADD, 200, 100); wait_idle(0); expect_result(0, 32'h2C, 0, 1'b1, 1'b0);
    apply_stimulus(0, OP_SUB, 5, 7);     wait_idle(0); expect_result(0, 32'hFE, 0, 1'b1, 1'b0);
    apply_stimulus(0, OP_SUB, 7, 5);     wait_idle(0); expect_result(0, 32'h02, 0, 1'b0, 1'b0);

    apply_stimulus(0, OP_MUL, 200, 3);
    repeat (2) @(negedge clock);
    a8 = 8'd1; b8 = 8'd1; mode8 = OP_ADD; start8 = 1'b1;
    @(negedge clock);
    start8 = 1'b0;
    wait_idle(0); expect_result(0, 32'h58, 32'h02, 1'b1, 1'b0);

    apply_stimulus(0, OP_DIV, 100, 7); wait_idle(0); expect_result(0, 14, 2, 1'b0, 1'b0);
    apply_stimulus(0, OP_MOD, 100, 7); wait_idle(0); expect_result(0, 2, 14, 1'b0, 1'b0);
    apply_stimulus(0, OP_DIV, 9, 0);   wait_idle(0); expect_result(0, 32'hFF, 9, 1'b0, 1'b1);
    apply_stimulus(0, OP_ADD, 1, 1);   wait_idle(0); expect_result(0, 2, 0, 1'b0, 1'b0);
    apply_stimulus(0, OP_MOD, 9, 0);   wait_idle(0); expect_result(0, 9, 32'hFF, 1'b0, 1'b1);
    apply_stimulus(0, opcode_t'(3'd6), 3, 4); wait_idle(0); expect_result(0, 0, 0, 1'b0, 1'b0);

    apply_stimulus(0, OP_MUL, 255, 255);
    repeat (2) @(negedge clock);
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    expect_result(0, 0, 0, 1'b0, 1'b0);
    reset_n = 1'b1;
    @(negedge clock);
    apply_stimulus(0, OP_MUL, 255, 255); wait_idle(0); expect_result(0, 32'h01, 32'hFE, 1'b1, 1'b0);

    apply_stimulus(1, OP_MUL, 32'hFFFF, 32'hFFFF); wait_idle(1);
    expect_result(1, 32'h0001, 32'hFFFE, 1'b1, 1'b0);
    apply_stimulus(1, OP_DIV, 32'hFFFF, 32'h0100); wait_idle(1);
    expect_result(1, 32'h00FF, 32'h00FF, 1'b0, 1'b0);

    // Random traffic on both widths, including starts that land while busy.
    for (int k = 0; k < 1500; k++) begin
      start8  = ($urandom_range(0, 2) == 0);
      start16 = ($urandom_range(0, 2) == 0);
      mode8   = opcode_t'(3'($urandom_range(0, 7)));
      mode16  = opcode_t'(3'($urandom_range(0, 7)));
      a8  = 8'($urandom);
      a16 = 16'($urandom);
      b8  = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      b16 = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom);
      @(negedge clock);
    end
    start8 = 1'b0;
    start16 = 1'b0;
    repeat (40) @(negedge clock);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
